// File: rtl/icache_pkg.sv
// icache_pkg: shared state encoding, default geometry and address-field helpers for the instruction cache
package icache_pkg;
   typedef enum logic [1:0] {IDLE, REQ, FILL, INSTALL} state_t;
   localparam int LINE_WORDS_DEF = 4;
   localparam int INDEX_BITS_DEF = 6;
   localparam int ADDR_BITS_DEF = 32;
   localparam int WO_BITS = $clog2(LINE_WORDS_DEF);
   localparam int TAG_BITS = ADDR_BITS_DEF - 2 - WO_BITS - INDEX_BITS_DEF;
   function automatic logic [63:0] addr_field(input logic [63:0] a, input int lsb, input int w);
      return (a >> lsb) & ((64'd1 << w) - 64'd1);
   endfunction
   function automatic logic [63:0] line_base(input logic [63:0] a, input int wo_bits);
      return a & ~((64'd1 << (wo_bits + 2)) - 64'd1);
   endfunction
endpackage

// File: rtl/icache_store.sv
// icache_store: valid/tag/data arrays with asynchronous read, one word write port, one tag write port
module icache_store
   import icache_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   parameter int INDEX_BITS = INDEX_BITS_DEF,
   parameter int TAG_W      = TAG_BITS,
   localparam int WB        = $clog2(LINE_WORDS),
   localparam int LINES     = 1 << INDEX_BITS
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clr,
   input  logic [INDEX_BITS-1:0] i_ridx,
   input  logic [WB-1:0]         i_rwo,
   output logic                  o_valid,
   output logic [TAG_W-1:0]      o_tag,
   output logic [31:0]           o_data,
   input  logic                  i_dwe,
   input  logic [INDEX_BITS-1:0] i_didx,
   input  logic [WB-1:0]         i_dwo,
   input  logic [31:0]           i_dwdata,
   input  logic                  i_twe,
   input  logic [INDEX_BITS-1:0] i_tidx,
   input  logic [TAG_W-1:0]      i_ttag
);
   logic [LINES-1:0] r_valid;
   logic [TAG_W-1:0] r_tag [LINES];
   logic [31:0]      r_data [LINES][LINE_WORDS];
   always_ff @(posedge clk) begin
      if (!rst || i_clr) r_valid <= '0;
      else if (i_twe) r_valid[i_tidx] <= 1'b1;
   end
   always_ff @(posedge clk) begin
      if (i_twe) r_tag[i_tidx] <= i_ttag;
      if (i_dwe) r_data[i_didx][i_dwo] <= i_dwdata;
   end
   assign o_valid = r_valid[i_ridx];
   assign o_tag   = r_tag[i_ridx];
   assign o_data  = r_data[i_ridx][i_rwo];
endmodule

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped read-only instruction cache with combinational hits and line refill on miss
module icache_direct
   import icache_pkg::*;
#(
   parameter int LINE_WORDS = LINE_WORDS_DEF,
   parameter int INDEX_BITS = INDEX_BITS_DEF,
   parameter int ADDR_BITS  = ADDR_BITS_DEF
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_BITS-1:0] pcF,
   input  logic                 req_i,
   input  logic                 flush_i,
   output logic [31:0]          instr,
   output logic                 stall_o,
   output logic                 mem_req,
   output logic [ADDR_BITS-1:0] mem_addr,
   input  logic                 mem_gnt,
   input  logic                 mem_rvalid,
   input  logic [31:0]          mem_rdata
);
   localparam int WB = $clog2(LINE_WORDS);
   localparam int TB = ADDR_BITS - 2 - WB - INDEX_BITS;
   state_t                r_state, w_next;
   logic [WB-1:0]         r_cnt;
   logic                  r_kill;
   logic [ADDR_BITS-1:0]  r_addr;
   logic [TB-1:0]         w_tag, w_mtag, w_rtag;
   logic [INDEX_BITS-1:0] w_idx, w_midx;
   logic [WB-1:0]         w_wo;
   logic                  w_valid, w_hit, w_miss, w_last;
   logic [31:0]           w_rdata;
   assign w_tag  = TB'(addr_field(64'(pcF), 2 + WB + INDEX_BITS, TB));
   assign w_idx  = INDEX_BITS'(addr_field(64'(pcF), 2 + WB, INDEX_BITS));
   assign w_wo   = WB'(addr_field(64'(pcF), 2, WB));
   assign w_mtag = TB'(addr_field(64'(r_addr), 2 + WB + INDEX_BITS, TB));
   assign w_midx = INDEX_BITS'(addr_field(64'(r_addr), 2 + WB, INDEX_BITS));
   // a flush in the same cycle as a fetch forces a miss so stale data is never returned
   assign w_hit    = req_i && !flush_i && w_valid && w_rtag == w_tag && r_state == IDLE;
   assign w_miss   = r_state == IDLE && req_i && !w_hit;
   assign w_last   = r_cnt == WB'(LINE_WORDS - 1);
   assign instr    = w_hit ? w_rdata : '0;
   assign stall_o  = r_state != IDLE || w_miss;
   assign mem_req  = r_state == REQ;
   assign mem_addr = r_addr;
   always_comb begin
      w_next = r_state;
      if (w_miss) w_next = REQ;
      if (r_state == REQ && mem_gnt) w_next = FILL;
      if (r_state == FILL && mem_rvalid && w_last) w_next = INSTALL;
      if (r_state == INSTALL) w_next = IDLE;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_kill  <= 1'b0;
         r_addr  <= '0;
      end else begin
         r_state <= w_next;
         if (w_miss) r_addr <= ADDR_BITS'(line_base(64'(pcF), WB));
         if (r_state == REQ && mem_gnt) r_cnt <= '0;
         else if (r_state == FILL && mem_rvalid) r_cnt <= r_cnt + 1'b1;
         r_kill <= r_state == INSTALL ? 1'b0 : (flush_i && r_state != IDLE) ? 1'b1 : r_kill;
      end
   end
   icache_store #(
      .LINE_WORDS(LINE_WORDS),
      .INDEX_BITS(INDEX_BITS),
      .TAG_W     (TB)
   ) u_store (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (flush_i),
      .i_ridx  (w_idx),
      .i_rwo   (w_wo),
      .o_valid (w_valid),
      .o_tag   (w_rtag),
      .o_data  (w_rdata),
      .i_dwe   (r_state == FILL && mem_rvalid),
      .i_didx  (w_midx),
      .i_dwo   (r_cnt),
      .i_dwdata(mem_rdata),
      .i_twe   (r_state == INSTALL && !r_kill && !flush_i),
      .i_tidx  (w_midx),
      .i_ttag  (w_mtag)
   );
endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed scoreboard bench with a behavioural line-fill memory
module tb_icache_direct;
   logic        clk = 1'b0, rst = 1'b0, req_i = 1'b0, flush_i = 1'b0;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0, stall_o, mem_req;
   logic [31:0] pcF = '0, mem_rdata = '0, instr, mem_addr;
   int          chk = 0, err = 0;
   int          gnt_dly = 2, gap = 0, flush_gnt = -1, n_gnt = 0, spur_n = 0, mem_en = 1;
   logic [31:0] q_exp[$];
   always #5 clk = ~clk;
   icache_direct dut (
      .clk(clk), .rst(rst), .pcF(pcF), .req_i(req_i), .flush_i(flush_i),
      .instr(instr), .stall_o(stall_o), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );
   function automatic logic [31:0] mdata(input logic [31:0] a);
      return (a >> 2) + 32'h90;
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk++;
      assert (got === exp) else begin
         err++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask
   task automatic fetch(input logic [31:0] a, input int exp_stall);
      logic [31:0] maddr;
      int          n;
      q_exp.push_back(mdata(a));
      pcF = a; req_i = 1'b1; n = 0; maddr = '0;
      #1;
      while (stall_o && n < 200) begin
         n++;
         if (mem_req && maddr == 0) maddr = mem_addr;
         @(negedge clk); #1;
      end
      check($sformatf("instr_%h", a), instr, q_exp.pop_front());
      check($sformatf("stall_cycles_%h", a), 32'(n), 32'(exp_stall));
      if (exp_stall > 0) check($sformatf("mem_addr_%h", a), maddr, a & 32'hFFFF_FFF0);
      else check($sformatf("no_mem_req_%h", a), {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      req_i = 1'b0;
   endtask
   initial begin : mem_model
      int          seen;
      logic [31:0] base;
      seen = 0;
      forever begin
         @(negedge clk);
         if (spur_n != seen) begin
            seen = spur_n;
            mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
         end else if (mem_en != 0 && mem_req) begin
            base = mem_addr;
            repeat (gnt_dly - 1) @(negedge clk);
            mem_gnt = 1'b1;
            n_gnt++;
            @(negedge clk);
            mem_gnt = 1'b0;
            check("req_drop_after_gnt", {31'd0, mem_req}, 32'd0);
            for (int i = 0; i < 4; i++) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mdata(base + 32'(4 * i));
               flush_i    = n_gnt == flush_gnt && i == 2;
               @(negedge clk);
               flush_i = 1'b0;
               if (gap != 0 && i < 3) begin
                  mem_rvalid = 1'b0; mem_rdata = 32'hBAD0_0000;
                  @(negedge clk);
               end
            end
            mem_rvalid = 1'b0;
         end
      end
   end
   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
   initial begin
      int g0;
      @(negedge clk);
      @(negedge clk);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_stall", {31'd0, stall_o}, 32'd0);
      check("rst_instr", instr, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      fetch(32'h40, 8);
      fetch(32'h4C, 0);
      fetch(32'h44, 0);
      fetch(32'h440, 8);
      fetch(32'h40, 8);
      spur_n++;
      repeat (3) begin
         @(negedge clk); #1;
         check("spur_mem_req", {31'd0, mem_req}, 32'd0);
         check("spur_stall", {31'd0, stall_o}, 32'd0);
      end
      @(negedge clk);
      fetch(32'h40, 0);
      fetch(32'h48, 0);
      gap = 1;
      fetch(32'hC0, 11);
      gap = 0;
      fetch(32'hC4, 0);
      fetch(32'hC8, 0);
      fetch(32'hCC, 0);
      g0 = n_gnt;
      flush_gnt = n_gnt + 1;
      fetch(32'h80, 16);
      check("flush_refill_grants", 32'(n_gnt - g0), 32'd2);
      fetch(32'h84, 0);
      fetch(32'hC0, 8);
      fetch(32'h40, 8);
      mem_en = 0;
      pcF = 32'h100; req_i = 1'b1;
      @(negedge clk);
      check("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
      rst = 1'b0; req_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("mid_rst_stall", {31'd0, stall_o}, 32'd0);
      check("mid_rst_mem_addr", mem_addr, 32'd0);
      check("mid_rst_instr", instr, 32'd0);
      mem_en = 1;
      @(negedge clk);
      fetch(32'h40, 8);
      fetch(32'h4C, 0);
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end
endmodule
